// File: rtl/fpga_input_pio_pkg.sv
// Shared register indices and sizing helper for the debounced push-button PIO.
package fpga_input_pio_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_RAW  = 2'd3;

    // At least one bit so a tiny debounce period still yields a legal counter.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fpga_input_pio_avs_if.sv
// Avalon-MM slave bus bundle as seen by the lightweight H2F bridge.
interface fpga_input_pio_avs_if;

    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/pio_debounce.sv
// One button bit: 2-FF synchroniser, hold-time debounce counter and press pulse.
module pio_debounce
    import fpga_input_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_HIGH       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic synced,
    output logic stable,
    output logic press
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= IDLE_HIGH;
            sync2_q  <= IDLE_HIGH;
            stable_q <= IDLE_HIGH;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // The counter clears on terminal count, so it never wraps past TERM.
    always_comb begin
        sync1_d  = pin_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press    = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            press    = (sync2_q != IDLE_HIGH);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign synced = sync2_q;
    assign stable = stable_q;

endmodule

// File: rtl/fpga_input_pio_avs.sv
// Debounced button PIO on Avalon-MM: DATA/MASK/EDGE/RAW registers and a maskable level irq.
module fpga_input_pio_avs
    import fpga_input_pio_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int IDLE_HIGH       = 1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    fpga_input_pio_avs_if.slave   avs,
    output logic                  irq,
    input  logic [WIDTH-1:0]      pins_in
);

    logic [WIDTH-1:0] synced, stable, press;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_HIGH       (IDLE_HIGH != 0)
        ) u_debounce (
            .clk    (clk_clk),
            .rst_n  (reset_reset_n),
            .pin_in (pins_in[i]),
            .synced (synced[i]),
            .stable (stable[i]),
            .press  (press[i])
        );
    end

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [31:0]      rd_word;
    logic             unused_wd;

    assign unused_wd = ^avs.avs_writedata[31:WIDTH];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    // Presses are OR-ed in after the W1C clear so a same-cycle capture wins.
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (avs.avs_write && avs.avs_address == REG_MASK) begin
            mask_d = avs.avs_writedata[WIDTH-1:0];
        end
        if (avs.avs_write && avs.avs_address == REG_EDGE) begin
            edge_d = edge_q & ~avs.avs_writedata[WIDTH-1:0];
        end
        edge_d = edge_d | press;
        irq_d  = |(edge_q & mask_q);
    end

    always_comb begin
        rd_word = '0;
        case (avs.avs_address)
            REG_DATA: rd_word[WIDTH-1:0] = stable;
            REG_MASK: rd_word[WIDTH-1:0] = mask_q;
            REG_EDGE: rd_word[WIDTH-1:0] = edge_q;
            default:  rd_word[WIDTH-1:0] = synced;
        endcase
        readdata_d = avs.avs_read ? rd_word : readdata_q;
    end

    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_fpga_input_pio_avs.sv
// Directed bench for fpga_input_pio_avs: read scoreboard plus irq and reset checks.
module tb_fpga_input_pio_avs;
    import fpga_input_pio_pkg::*;

    localparam int WIDTH = 3;
    localparam int DEB   = 4;

    logic             clk_clk       = 1'b0;
    logic             reset_reset_n = 1'b0;
    logic [WIDTH-1:0] pins_in       = '1;
    logic             irq;

    fpga_input_pio_avs_if bus();

    fpga_input_pio_avs #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .IDLE_HIGH       (1)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs           (bus),
        .irq           (irq),
        .pins_in       (pins_in)
    );

    always #5 clk_clk = ~clk_clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One bus cycle; reads push their expectation and are checked once readdata is valid.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rexp, input string tag);
        bus.avs_write     = wr;
        bus.avs_read      = rd;
        bus.avs_address   = addr;
        bus.avs_writedata = wdata;
        if (rd) begin
            exp_q.push_back(rexp);
            tag_q.push_back(tag);
        end
        @(posedge clk_clk);
        #1;
        bus.avs_write = 1'b0;
        bus.avs_read  = 1'b0;
        if (rd) begin
            if (exp_q.size() == 0) begin
                checkOutput({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                checkOutput(tag_q.pop_front(), bus.avs_readdata, exp_q.pop_front());
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data, 32'd0, "write");
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp_val, input string tag);
        applyStimulus(1'b0, 1'b1, addr, 32'd0, exp_val, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    initial begin
        bus.avs_write     = 1'b0;
        bus.avs_read      = 1'b0;
        bus.avs_address   = 2'd0;
        bus.avs_writedata = 32'd0;

        // Reset state
        idle(3);
        checkOutput("reset_readdata", bus.avs_readdata, 32'd0);
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        reset_reset_n = 1'b1;
        idle(2);
        bus_read(REG_DATA, 32'h7, "rst_data");
        bus_read(REG_MASK, 32'h0, "rst_mask");
        bus_read(REG_EDGE, 32'h0, "rst_edge");
        bus_read(REG_RAW,  32'h7, "rst_raw");
        checkOutput("rst_irq_after_release", {31'd0, irq}, 32'd0);
        bus_write(REG_DATA, 32'h0);
        bus_read(REG_DATA, 32'h7, "data_read_only");
        bus_write(REG_MASK, 32'hFFFF_FFF0);
        bus_read(REG_MASK, 32'h0, "mask_upper_bits_ignored");

        // Clean press on bit1: stable flips 6 edges after the pin, readdata one edge later
        pins_in[1] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            bus_read(REG_DATA, (c < 7) ? 32'h7 : 32'h5, $sformatf("press_data_c%0d", c));
        end
        checkOutput("press_irq_masked", {31'd0, irq}, 32'd0);
        bus_read(REG_EDGE, 32'h2, "press_edge");
        pins_in[1] = 1'b1;
        idle(8);
        bus_read(REG_DATA, 32'h7, "release_data");
        bus_read(REG_EDGE, 32'h2, "release_edge_sticky");
        bus_write(REG_EDGE, 32'h2);
        bus_read(REG_EDGE, 32'h0, "edge_w1c");

        // Bounce on bit0 never outlasts the debounce window
        for (int i = 0; i < 10; i++) begin
            pins_in[0] = i[0];
            idle(2);
        end
        pins_in[0] = 1'b1;
        idle(8);
        bus_read(REG_DATA, 32'h7, "bounce_data");
        bus_read(REG_EDGE, 32'h0, "bounce_edge");

        // IRQ path on bit2, with RAW tracking the synchronised pin
        bus_write(REG_MASK, 32'h4);
        checkOutput("irq_after_mask_no_edge", {31'd0, irq}, 32'd0);
        pins_in[2] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            bus_read(REG_RAW, (c >= 3) ? 32'h3 : 32'h7, $sformatf("irq_raw_c%0d", c));
            checkOutput($sformatf("irq_level_c%0d", c), {31'd0, irq}, (c >= 7) ? 32'd1 : 32'd0);
        end
        bus_read(REG_EDGE, 32'h4, "irq_edge_set");
        bus_write(REG_EDGE, 32'h4);
        checkOutput("irq_on_clear_edge", {31'd0, irq}, 32'd1);
        idle(1);
        checkOutput("irq_after_clear", {31'd0, irq}, 32'd0);
        bus_read(REG_EDGE, 32'h0, "irq_edge_cleared");
        pins_in[2] = 1'b1;
        idle(8);
        bus_write(REG_MASK, 32'h0);
        bus_read(REG_MASK, 32'h0, "mask_cleared");

        // Set/clear race on bit0: the clear lands on the press-pulse edge
        pins_in[0] = 1'b0;
        idle(5);
        bus_write(REG_EDGE, 32'h1);
        bus_read(REG_EDGE, 32'h1, "race_set_wins");
        bus_read(REG_DATA, 32'h6, "race_data");
        applyStimulus(1'b1, 1'b1, REG_EDGE, 32'h1, 32'h1, "rw_edge_preclear");
        bus_read(REG_EDGE, 32'h0, "rw_edge_cleared");
        pins_in[0] = 1'b1;
        idle(8);

        // Reset in the middle of a debounce count
        bus_write(REG_MASK, 32'h7);
        pins_in[0] = 1'b0;
        bus_read(REG_MASK, 32'h7, "pre_reset_mask");
        idle(3);
        pins_in[0]    = 1'b1;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("midreset_readdata", bus.avs_readdata, 32'd0);
        checkOutput("midreset_irq", {31'd0, irq}, 32'd0);
        idle(2);
        reset_reset_n = 1'b1;
        idle(10);
        bus_read(REG_DATA, 32'h7, "post_reset_data");
        bus_read(REG_EDGE, 32'h0, "post_reset_edge");
        bus_read(REG_MASK, 32'h0, "post_reset_mask");
        checkOutput("post_reset_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
